dcache_line_ctrl: RTL

Miss/refill controller for the 2-way, 64-set, 64-byte-line data cache data array. It holds tag, valid, dirty and LRU state and resolves hit/miss for each CPU request. On a miss it sequences victim write-back and line refill through a line-granular memory bridge, then drives the data array's `hit`, `lru`, `cached`, `write_back` and `refresh` controls. It sits between the CPU memory stage and the data array, with the AXI burst bridge below it.

---
 rtl/dcache_line_ctrl_pkg.sv | 35 +++
 rtl/dcache_line_ctrl_tag_store.sv | 66 ++++++
 rtl/dcache_line_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/dcache_line_ctrl_pkg.sv
// Shared definitions for the data cache line controller.
// Holds the address split widths, line width, FSM state encoding and the
// victim-selection rule used by both the tag store users and the FSM.
package dcache_line_ctrl_pkg;

  localparam int TAG_WIDTH       = 20;
  localparam int INDEX_WIDTH     = 6;
  localparam int OFFSET_WIDTH    = 6;
  localparam int CACHELINE_WIDTH = 512;
  localparam int HIT_WIDTH       = 2;

  typedef enum logic [2:0] {
    ST_LOOKUP = 3'd0,
    ST_WB_RD  = 3'd1,
    ST_WB_CAP = 3'd2,
    ST_WB_REQ = 3'd3,
    ST_RD_REQ = 3'd4,
    ST_REFILL = 3'd5
  } state_e;

  // Replacement choice: fill an empty way first, otherwise follow the LRU bit.
  function automatic logic pick_victim(input logic [HIT_WIDTH-1:0] valid,
                                       input logic lru_bit);
    logic way;
    if (!valid[0]) begin
      way = 1'b0;
    end else if (!valid[1]) begin
      way = 1'b1;
    end else begin
      way = lru_bit;
    end
    return way;
  endfunction

endpackage

// File: rtl/dcache_line_ctrl_tag_store.sv
// cache_tag_store: per-set tag/valid/dirty/LRU state for the 2-way cache.
// Ports:
//   clk, rst          - clock, synchronous active-high reset (clears valid/dirty/lru)
//   i_idx             - set index used for both the lookup and the update
//   o_tag/o_valid/o_dirty/o_lru - combinational view of the indexed set
//   i_hit_upd/i_hit_way/i_hit_dirty - hit bookkeeping (LRU flip, optional dirty set)
//   i_fill/i_fill_way/i_fill_tag    - refill install (tag, valid=1, dirty=0, LRU flip)
module cache_tag_store
  import dcache_line_ctrl_pkg::*;
#(
  parameter int TAG_W = 20,
  parameter int SETS  = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [INDEX_WIDTH-1:0]              i_idx,
  output logic [HIT_WIDTH-1:0][TAG_W-1:0]     o_tag,
  output logic [HIT_WIDTH-1:0]                o_valid,
  output logic [HIT_WIDTH-1:0]                o_dirty,
  output logic                                o_lru,
  input  logic                                i_hit_upd,
  input  logic                                i_hit_way,
  input  logic                                i_hit_dirty,
  input  logic                                i_fill,
  input  logic                                i_fill_way,
  input  logic [TAG_W-1:0]                    i_fill_tag
);

  logic [HIT_WIDTH-1:0][TAG_W-1:0] r_tag   [SETS];
  logic [HIT_WIDTH-1:0]            r_valid [SETS];
  logic [HIT_WIDTH-1:0]            r_dirty [SETS];
  logic [SETS-1:0]                 r_lru;

  assign o_tag   = r_tag[i_idx];
  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_lru   = r_lru[i_idx];

  // Tags need no reset: they are meaningless while the matching valid bit is clear.
  always_ff @(posedge clk) begin
    if (i_fill) begin
      r_tag[i_idx][i_fill_way] <= i_fill_tag;
    end
  end

  // Valid/dirty/LRU bookkeeping; a refill takes priority over hit bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= {HIT_WIDTH{1'b0}};
        r_dirty[s] <= {HIT_WIDTH{1'b0}};
      end
      r_lru <= {SETS{1'b0}};
    end else if (i_fill) begin
      r_valid[i_idx][i_fill_way] <= 1'b1;
      r_dirty[i_idx][i_fill_way] <= 1'b0;
      r_lru[i_idx]               <= ~i_fill_way;
    end else if (i_hit_upd) begin
      r_lru[i_idx] <= ~i_hit_way;
      if (i_hit_dirty) begin
        r_dirty[i_idx][i_hit_way] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcache_line_ctrl.sv
// dcache_line_ctrl: miss/refill controller for the 2-way, 64-set, 64-byte-line
// data cache. Resolves hits, and on a cached miss sequences an optional victim
// write-back followed by a line refill through a line-granular bridge.
// Ports:
//   clk, rst                              - clock, synchronous active-high reset
//   i_req_valid/i_req_wen/i_req_addr/i_req_cached - CPU request (held while o_stall)
//   o_stall                               - CPU must hold its request
//   o_hit/o_lru/o_cached/o_write_back/o_refresh - data array controls
//   o_refill_line                         - refill line presented to the data array
//   i_cacheline_old                       - victim line, valid the cycle after o_write_back
//   o_wr_req/o_wr_addr/o_wr_line/i_wr_done - write-line handshake to the bridge
//   o_rd_req/o_rd_addr/i_rd_valid/i_rd_line - read-line handshake to the bridge
module dcache_line_ctrl
  import dcache_line_ctrl_pkg::*;
#(
  parameter int TAG_W = 20,
  parameter int SETS  = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_req_valid,
  input  logic [3:0]                   i_req_wen,
  input  logic [31:0]                  i_req_addr,
  input  logic                         i_req_cached,
  output logic                         o_stall,
  output logic [HIT_WIDTH-1:0]         o_hit,
  output logic                         o_lru,
  output logic                         o_cached,
  output logic                         o_write_back,
  output logic                         o_refresh,
  output logic [CACHELINE_WIDTH-1:0]   o_refill_line,
  input  logic [CACHELINE_WIDTH-1:0]   i_cacheline_old,
  output logic                         o_wr_req,
  output logic [31:0]                  o_wr_addr,
  output logic [CACHELINE_WIDTH-1:0]   o_wr_line,
  input  logic                         i_wr_done,
  output logic                         o_rd_req,
  output logic [31:0]                  o_rd_addr,
  input  logic                         i_rd_valid,
  input  logic [CACHELINE_WIDTH-1:0]   i_rd_line
);

  state_e                           r_state;
  state_e                           w_state_nxt;
  logic                             r_victim;
  logic [TAG_W-1:0]                 r_victim_tag;
  logic [31:0]                      r_wr_addr;
  logic [CACHELINE_WIDTH-1:0]       r_wr_line;
  logic [CACHELINE_WIDTH-1:0]       r_refill_line;

  logic [INDEX_WIDTH-1:0]           w_idx;
  logic [TAG_W-1:0]                 w_tag;
  logic [HIT_WIDTH-1:0][TAG_W-1:0]  w_tag_rd;
  logic [HIT_WIDTH-1:0]             w_valid_rd;
  logic [HIT_WIDTH-1:0]             w_dirty_rd;
  logic                             w_lru_rd;
  logic [HIT_WIDTH-1:0]             w_hit;
  logic                             w_miss;
  logic                             w_victim;
  logic                             w_addr_offset_unused;

  assign w_idx                = i_req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign w_tag                = i_req_addr[31 -: TAG_W];
  assign w_addr_offset_unused = ^i_req_addr[OFFSET_WIDTH-1:0];
  assign w_victim             = pick_victim(w_valid_rd, w_lru_rd);

  cache_tag_store #(
    .TAG_W (TAG_W),
    .SETS  (SETS)
  ) u_tag_store (
    .clk         (clk),
    .rst         (rst),
    .i_idx       (w_idx),
    .o_tag       (w_tag_rd),
    .o_valid     (w_valid_rd),
    .o_dirty     (w_dirty_rd),
    .o_lru       (w_lru_rd),
    .i_hit_upd   (|w_hit),
    .i_hit_way   (w_hit[1]),
    .i_hit_dirty (|i_req_wen),
    .i_fill      (r_state == ST_REFILL),
    .i_fill_way  (r_victim),
    .i_fill_tag  (w_tag)
  );

  // Hit detection is only live in LOOKUP so the replay after a refill is the
  // single cycle that records the access in the LRU/dirty state.
  always_comb begin
    w_hit = {HIT_WIDTH{1'b0}};
    for (int w = 0; w < HIT_WIDTH; w++) begin
      w_hit[w] = (r_state == ST_LOOKUP) & i_req_valid & i_req_cached &
                 w_valid_rd[w] & (w_tag_rd[w] == w_tag);
    end
    w_miss = (r_state == ST_LOOKUP) & i_req_valid & i_req_cached & ~(|w_hit);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOOKUP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; a valid and dirty victim detours through write-back.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOOKUP: begin
        if (w_miss) begin
          if (w_valid_rd[w_victim] & w_dirty_rd[w_victim]) begin
            w_state_nxt = ST_WB_RD;
          end else begin
            w_state_nxt = ST_RD_REQ;
          end
        end else begin
          w_state_nxt = ST_LOOKUP;
        end
      end
      ST_WB_RD:  w_state_nxt = ST_WB_CAP;
      ST_WB_CAP: w_state_nxt = ST_WB_REQ;
      ST_WB_REQ: begin
        if (i_wr_done) begin
          w_state_nxt = ST_RD_REQ;
        end else begin
          w_state_nxt = ST_WB_REQ;
        end
      end
      ST_RD_REQ: begin
        if (i_rd_valid) begin
          w_state_nxt = ST_REFILL;
        end else begin
          w_state_nxt = ST_RD_REQ;
        end
      end
      ST_REFILL: w_state_nxt = ST_LOOKUP;
      default:   w_state_nxt = ST_LOOKUP;
    endcase
  end

  // Miss context: the victim is frozen at miss detection so the LRU output and
  // refill target cannot move while the set state is being rewritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_victim      <= 1'b0;
      r_victim_tag  <= {TAG_W{1'b0}};
      r_wr_addr     <= 32'h0000_0000;
      r_wr_line     <= {CACHELINE_WIDTH{1'b0}};
      r_refill_line <= {CACHELINE_WIDTH{1'b0}};
    end else begin
      if (w_miss) begin
        r_victim     <= w_victim;
        r_victim_tag <= w_tag_rd[w_victim];
      end
      if (r_state == ST_WB_CAP) begin
        r_wr_line <= i_cacheline_old;
        r_wr_addr <= {r_victim_tag, w_idx, 6'b000000};
      end
      if ((r_state == ST_RD_REQ) && i_rd_valid) begin
        r_refill_line <= i_rd_line;
      end
    end
  end

  // FSM output decode.
  always_comb begin
    o_hit         = w_hit;
    o_cached      = i_req_cached;
    o_wr_addr     = r_wr_addr;
    o_wr_line     = r_wr_line;
    o_refill_line = r_refill_line;
    o_stall       = 1'b1;
    o_lru         = r_victim;
    o_write_back  = 1'b0;
    o_refresh     = 1'b0;
    o_wr_req      = 1'b0;
    o_rd_req      = 1'b0;
    o_rd_addr     = 32'h0000_0000;
    case (r_state)
      ST_LOOKUP: begin
        o_stall = w_miss;
        o_lru   = w_victim;
      end
      ST_WB_RD:  o_write_back = 1'b1;
      ST_WB_CAP: o_write_back = 1'b0;
      ST_WB_REQ: o_wr_req     = 1'b1;
      ST_RD_REQ: begin
        o_rd_req  = 1'b1;
        o_rd_addr = {i_req_addr[31:OFFSET_WIDTH], 6'b000000};
      end
      ST_REFILL: o_refresh = 1'b1;
      default:   o_stall   = 1'b1;
    endcase
  end

endmodule
